nco_dual_axil_regs: RTL

AXI4-Lite slave register file sitting between the processor interconnect (or the master verification agent) and the dual NCO core. It accepts single-beat writes and reads on four 32-bit registers at offsets 0x0–0xC and drives their contents to the NCO as static configuration. It pulses an update strobe whenever a register changes. Every register is read/write and reads back exactly what was last written, honouring byte strobes.

---
 rtl/nco_dual_axil_regs.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/nco_dual_axil_regs.sv
// AXI4-Lite register file holding the dual-NCO configuration: four 32-bit R/W
// registers with byte strobes, plus a one-cycle update strobe per committed write.
module nco_dual_axil_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   phase_inc_a,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   phase_inc_b,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   nco_ctrl,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   nco_aux,
  output logic                            cfg_update
);
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int NB = DW / 8;

  logic [3:0][DW-1:0] regs_q, regs_d;
  logic               aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [1:0]         aw_addr_q, aw_addr_d;
  logic [DW-1:0]      wdata_q, wdata_d, rdata_q, rdata_d;
  logic [NB-1:0]      wstrb_q, wstrb_d;
  logic               bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic               awready_q, awready_d, wready_q, wready_d, arready_q, arready_d;
  logic               cfg_q, commit;

  // Protection bits and the byte-offset address bits carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  always_comb begin
    regs_d    = regs_q;
    aw_held_d = aw_held_q;
    aw_addr_d = aw_addr_q;
    w_held_d  = w_held_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    commit    = aw_held_q && w_held_q;

    if (commit) begin
      for (int k = 0; k < NB; k++)
        if (wstrb_q[k]) regs_d[aw_addr_q][8*k +: 8] = wdata_q[8*k +: 8];
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
    end else if (bvalid_q && S_AXI_BREADY) begin
      bvalid_d = 1'b0;
    end

    if (S_AXI_AWVALID && awready_q) begin
      aw_held_d = 1'b1;
      aw_addr_d = S_AXI_AWADDR[3:2];
    end
    if (S_AXI_WVALID && wready_q) begin
      w_held_d = 1'b1;
      wdata_d  = S_AXI_WDATA;
      wstrb_d  = S_AXI_WSTRB;
    end

    // Reads sample the pre-commit register image, so a same-edge write is not seen.
    if (S_AXI_ARVALID && arready_q) begin
      rvalid_d = 1'b1;
      rdata_d  = regs_q[S_AXI_ARADDR[3:2]];
    end else if (rvalid_q && S_AXI_RREADY) begin
      rvalid_d = 1'b0;
    end

    awready_d = !aw_held_d && !bvalid_d;
    wready_d  = !w_held_d && !bvalid_d;
    arready_d = !rvalid_d;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      regs_q    <= '0;
      aw_held_q <= 1'b0;
      aw_addr_q <= '0;
      w_held_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      arready_q <= 1'b0;
      cfg_q     <= 1'b0;
    end else begin
      regs_q    <= regs_d;
      aw_held_q <= aw_held_d;
      aw_addr_q <= aw_addr_d;
      w_held_q  <= w_held_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      arready_q <= arready_d;
      cfg_q     <= commit;
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_RRESP   = 2'b00;
  assign phase_inc_a   = regs_q[0];
  assign phase_inc_b   = regs_q[1];
  assign nco_ctrl      = regs_q[2];
  assign nco_aux       = regs_q[3];
  assign cfg_update    = cfg_q;
endmodule
